// File: rtl/regbank_reader.sv
// regbank_reader
// Read-side access unit for the 16x16 register bank.
//   - Decodes a write request into one-hot bank write enables (rEnable) and
//     passes the write data straight through (writePort).
//   - Accepts dual-operand read requests over a valid/ready handshake. Each
//     operand is captured with same-cycle write bypass and stored in a
//     2-entry response FIFO whose head drives rdata_a/rdata_b.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   r0..r15               current bank register values
//   wr_en/wr_addr/wr_data write request; wr_data is also the bypass source
//   rEnable, writePort    one-hot write enables and write data to the bank
//   req_valid/req_ready   read request handshake, raddr_a/raddr_b operands
//   rsp_valid/rsp_ready   response handshake, rdata_a/rdata_b head operands
// Parameter ZERO_R0: register 0 reads as zero and is never written.

module regbank_reader #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    input  logic [15:0] r8,
    input  logic [15:0] r9,
    input  logic [15:0] r10,
    input  logic [15:0] r11,
    input  logic [15:0] r12,
    input  logic [15:0] r13,
    input  logic [15:0] r14,
    input  logic [15:0] r15,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rEnable,
    output logic [15:0] writePort,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b
);

    logic [15:0] bankVal [16];

    assign bankVal[0]  = r0;
    assign bankVal[1]  = r1;
    assign bankVal[2]  = r2;
    assign bankVal[3]  = r3;
    assign bankVal[4]  = r4;
    assign bankVal[5]  = r5;
    assign bankVal[6]  = r6;
    assign bankVal[7]  = r7;
    assign bankVal[8]  = r8;
    assign bankVal[9]  = r9;
    assign bankVal[10] = r10;
    assign bankVal[11] = r11;
    assign bankVal[12] = r12;
    assign bankVal[13] = r13;
    assign bankVal[14] = r14;
    assign bankVal[15] = r15;

    // Write decode. Reset suppresses forwarding so writes presented while
    // the unit is held in reset never reach the bank.
    always_comb begin
        rEnable = '0;
        if (wr_en && !reset && !(ZERO_R0 && (wr_addr == 4'd0))) begin
            rEnable[wr_addr] = 1'b1;
        end
    end

    assign writePort = wr_data;

    // Operand capture values. The zero-register rule has priority over the
    // bypass, which in turn overrides the bank value so that a same-cycle
    // write to the addressed register is observed by the read.
    logic [15:0] opA;
    logic [15:0] opB;

    always_comb begin
        opA = bankVal[raddr_a];
        if (wr_en && (wr_addr == raddr_a)) begin
            opA = wr_data;
        end
        if (ZERO_R0 && (raddr_a == 4'd0)) begin
            opA = '0;
        end
        opB = bankVal[raddr_b];
        if (wr_en && (wr_addr == raddr_b)) begin
            opB = wr_data;
        end
        if (ZERO_R0 && (raddr_b == 4'd0)) begin
            opB = '0;
        end
    end

    // Response FIFO: headQ is always the oldest entry, tailQ the second one.
    // Entries are {operand a, operand b} snapshots taken at acceptance.
    logic [1:0]  countQ, countD;
    logic [31:0] headQ, headD;
    logic [31:0] tailQ, tailD;
    logic        push;
    logic        pop;

    assign req_ready = (countQ != 2'd2) && !reset;
    assign rsp_valid = (countQ != 2'd0) && !reset;
    assign rdata_a   = reset ? 16'h0000 : headQ[31:16];
    assign rdata_b   = reset ? 16'h0000 : headQ[15:0];
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Push and pop together can only happen with one entry stored, so the
    // new entry replaces the head directly. A pop that empties the FIFO
    // leaves the head untouched so the outputs hold their last value.
    always_comb begin
        countD = countQ;
        headD  = headQ;
        tailD  = tailQ;
        if (push && pop) begin
            headD = {opA, opB};
        end else if (pop) begin
            countD = countQ - 2'd1;
            if (countQ == 2'd2) begin
                headD = tailQ;
            end
        end else if (push) begin
            countD = countQ + 2'd1;
            if (countQ == 2'd0) begin
                headD = {opA, opB};
            end else begin
                tailD = {opA, opB};
            end
        end
    end

    // FIFO state register; reset discards any buffered responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            countQ <= 2'd0;
            headQ  <= '0;
            tailQ  <= '0;
        end else begin
            countQ <= countD;
            headQ  <= headD;
            tailQ  <= tailD;
        end
    end

endmodule

// File: doc/regbank_reader.md
# regbank_reader

Read-side access unit for the 16×16 register bank. It decodes write requests into the bank's one-hot write enables and serves dual-operand read requests through a valid/ready handshake. Read data is captured with same-cycle write bypass and held in a 2-entry response buffer. It sits between the bank and the datapath's operand-fetch stage.

## Interface
- ZERO_R0, default 0: when 1, register 0 reads as 16'h0000 and is never write-enabled.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- r0 … r15  input  16 each  current bank register values.
- wr_en  input  1  write request this cycle.
- wr_addr  input  4  register to write.
- wr_data  input  16  write data; also the bypass source.
- rEnable  output  16  one-hot write enables to the bank.
- writePort  output  16  data to the bank; equals wr_data.
- req_valid  input  1  read request present.
- req_ready  output  1  unit can accept a request.
- raddr_a, raddr_b  input  4 each  operand register addresses.
- rsp_valid  output  1  head response present.
- rsp_ready  input  1  consumer takes the head response.
- rdata_a, rdata_b  output  16 each  head response operands.

## Operation
- Write decode is combinational.
  - rEnable[i] = wr_en && (wr_addr == i) && !reset.
  - When ZERO_R0=1, rEnable[0] = 0 always.
  - At most one bit of rEnable is set.
- Accept: a request is accepted on a posedge where req_valid && req_ready.
- Capture: on acceptance, each operand value is computed as follows (a and b are evaluated independently):
  - If ZERO_R0=1 and the address is 0, the value is 0.
  - Otherwise, if wr_en and wr_addr equals the address, the value is wr_data (bypass).
  - Otherwise, the value is r[address].
- Snapshot semantics: a buffered entry keeps its captured value. Later writes to the same register do not update entries already in the buffer.
- Response buffer: 2-entry FIFO with count ∈ {0,1,2}.
  - req_ready = (count < 2) && !reset.
  - Head entry drives rdata_a and rdata_b; rsp_valid = (count ≠ 0).
  - Pop occurs on a posedge where rsp_valid && rsp_ready.
- Simultaneous push and pop:
  - count 1 → stays 1; the new entry becomes head on the next cycle.
  - count 2: no push is possible (req_ready=0), so only the pop occurs and count → 1.
- Full: req_ready deasserts in the cycle after the second entry is stored. It reasserts in the cycle after a pop.
- Empty: rdata_a and rdata_b hold their last head value and are don't-care to consumers. The bench checks them only when rsp_valid=1.
- Order: responses leave in acceptance order, with no reordering or dropping.
- Reset, including mid-operation:
  - count → 0, so all buffered entries are discarded.
  - rsp_valid=0, rdata_a=rdata_b=0.
  - req_ready=0 and rEnable=0 while reset is high.
  - Writes presented during reset are not forwarded to the bank.

## Timing
- Write: wr_en in cycle N → rEnable asserted in cycle N → bank updated at the end of cycle N → visible on rX in cycle N+1.
- Read latency: request accepted at the end of cycle N → rsp_valid=1 with data in cycle N+1, provided the buffer was empty or popped in cycle N.
- Throughput: 1 request per cycle sustained while rsp_ready is held high.
- Backpressure: with rsp_ready=0, exactly 2 requests are accepted, then req_ready=0.
- Bypass timing: a write and a read to the same register in the same cycle return the new data. A read in a cycle without that write returns bank state.
- First cycle after reset deasserts: req_ready=1, rsp_valid=0.

## Test plan
- Write/read basic:
  - Stimulus: write r5=16'hBEEF in cycle 0; request a=5, b=0 in cycle 2.
  - Expected: rEnable=16'h0020 in cycle 0; rsp in cycle 3 with rdata_a=BEEF, rdata_b=0000 (after reset).
- Same-cycle bypass:
  - Stimulus: r3 holds 16'h1111; in one cycle, write r3=16'h2222 and request a=3, b=3.
  - Expected: response a=b=2222; r3=2222 on the next cycle.
- Backpressure:
  - Stimulus: rsp_ready=0; issue requests (a=1,b=2), (a=3,b=4), (a=5,b=6) back to back.
  - Expected: first two accepted, req_ready=0 afterwards, third held.
  - Then raise rsp_ready: three responses in order, third accepted one cycle after the first pop.
- Snapshot:
  - Stimulus: r7=16'h00AA; with rsp_ready=0, accept a=7; then write r7=16'h00BB; then pop.
  - Expected: rdata_a=00AA; a subsequent request of r7 returns 00BB.
- Reset mid-operation:
  - Stimulus: buffer holds 2 entries; assert reset for 1 cycle while wr_en=1 to r9.
  - Expected: rsp_valid=0, rdata=0, rEnable=0 during reset; r9 unchanged; req_ready=1 after reset.
- ZERO_R0=1:
  - Stimulus: write r0=16'hFFFF, then read a=0.
  - Expected: rEnable=0000 and rdata_a=0000.
  - With ZERO_R0=0, the same sequence gives rEnable=0001 and rdata_a=FFFF.
